dmem_arbiter: RTL and testbench

Two-requester arbiter for the single-port, synchronous-read data memory. Port 0 is the core load/store path and port 1 is the external master (boot loader / DMA). The block grants one access per cycle and drives the shared memory port. It routes each 1-cycle-latency read response back to the requester that issued it. Fixed priority favours the core, with an anti-starvation counter that guarantees the external master forward progress.

---
 rtl/dmem_arbiter_pkg.sv | 23 ++
 rtl/dmem_starve_ctr.sv | 28 ++
 rtl/dmem_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: access size encoding and
// priority state.
package dmem_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    MEM_RD = 2'b00,
    MEM_B  = 2'b01,
    MEM_H  = 2'b10,
    MEM_W  = 2'b11
  } mem_size_t;

  typedef enum logic {
    CORE_PRI = 1'b0,
    EXT_PRI  = 1'b1
  } arb_state_t;

  function automatic logic is_read(input logic [1:0] we);
    return mem_size_t'(we) == MEM_RD;
  endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating 8-bit wait counter for the external port; starved flags that
// the count has reached the limit.
module dmem_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic starved
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && count != LIMIT)
      count <= count + 8'd1;
  end

  assign starved = (count == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port synchronous-read data memory: core
// has fixed priority, the external master is promoted after STARVE_LIMIT
// blocked cycles. Read responses are steered back to the issuing port.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [1:0]        core_req_we,
  input  logic [AW-1:0]     core_req_addr,
  input  logic [DATA_W-1:0] core_req_wdata,
  output logic              core_rsp_valid,
  output logic [DATA_W-1:0] core_rsp_data,
  input  logic              ext_req_valid,
  output logic              ext_req_ready,
  input  logic [1:0]        ext_req_we,
  input  logic [AW-1:0]     ext_req_addr,
  input  logic [DATA_W-1:0] ext_req_wdata,
  output logic              ext_rsp_valid,
  output logic [DATA_W-1:0] ext_rsp_data,
  output logic              mem_en,
  output logic [1:0]        mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rd_data
);

  arb_state_t state, state_nxt;
  logic       core_grant, ext_grant;
  logic       starved;
  logic       rsp_pending, rsp_owner;

  dmem_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     (ext_req_valid && !ext_grant),
    .clr     (ext_grant || !ext_req_valid),
    .starved (starved)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= CORE_PRI;
    else
      state <= state_nxt;
  end

  // An ext grant in the cycle the counter is saturated already serves the
  // starved master, so promotion is skipped.
  always_comb begin
    state_nxt = state;
    case (state)
      CORE_PRI: if (starved && !ext_grant)           state_nxt = EXT_PRI;
      EXT_PRI:  if (ext_grant || !ext_req_valid)     state_nxt = CORE_PRI;
      default:                                       state_nxt = CORE_PRI;
    endcase
  end

  always_comb begin
    core_grant = 1'b0;
    ext_grant  = 1'b0;
    if (!rst) begin
      if (state == EXT_PRI) begin
        ext_grant  = ext_req_valid;
        core_grant = core_req_valid && !ext_req_valid;
      end else begin
        core_grant = core_req_valid;
        ext_grant  = ext_req_valid && !core_req_valid;
      end
    end
  end

  assign core_req_ready = core_grant;
  assign ext_req_ready  = ext_grant;

  always_comb begin
    mem_en    = core_grant || ext_grant;
    mem_we    = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_grant) begin
      mem_we    = core_req_we;
      mem_addr  = core_req_addr;
      mem_wdata = core_req_wdata;
    end else if (ext_grant) begin
      mem_we    = ext_req_we;
      mem_addr  = ext_req_addr;
      mem_wdata = ext_req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_pending <= 1'b0;
      rsp_owner   <= 1'b0;
    end else begin
      rsp_pending <= mem_en && is_read(mem_we);
      rsp_owner   <= ext_grant;
    end
  end

  assign core_rsp_valid = rsp_pending && !rsp_owner;
  assign ext_rsp_valid  = rsp_pending && rsp_owner;
  assign core_rsp_data  = core_rsp_valid ? mem_rd_data : '0;
  assign ext_rsp_data   = ext_rsp_valid  ? mem_rd_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scenario bench for dmem_arbiter: per-feature tasks check grants inline,
// read responses are matched against a scoreboard queue by a monitor.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW    = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req_valid, core_req_ready;
  logic [1:0]    core_req_we;
  logic [AW-1:0] core_req_addr;
  logic [31:0]   core_req_wdata;
  logic          core_rsp_valid;
  logic [31:0]   core_rsp_data;
  logic          ext_req_valid, ext_req_ready;
  logic [1:0]    ext_req_we;
  logic [AW-1:0] ext_req_addr;
  logic [31:0]   ext_req_wdata;
  logic          ext_rsp_valid;
  logic [31:0]   ext_rsp_data;
  logic          mem_en;
  logic [1:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rd_data = 32'h0;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .core_req_valid (core_req_valid),
    .core_req_ready (core_req_ready),
    .core_req_we    (core_req_we),
    .core_req_addr  (core_req_addr),
    .core_req_wdata (core_req_wdata),
    .core_rsp_valid (core_rsp_valid),
    .core_rsp_data  (core_rsp_data),
    .ext_req_valid  (ext_req_valid),
    .ext_req_ready  (ext_req_ready),
    .ext_req_we     (ext_req_we),
    .ext_req_addr   (ext_req_addr),
    .ext_req_wdata  (ext_req_wdata),
    .ext_rsp_valid  (ext_rsp_valid),
    .ext_rsp_data   (ext_rsp_data),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rd_data    (mem_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_func(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  // Synchronous-read memory model; garbage when no read was enabled.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rd_data <= (mem_en && mem_we == 2'b00) ? mem_func(mem_addr) : 32'hBAD0BAD0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        total++; bad++;
        $display("FAIL rsp_missed: response due cycle %0d still queued at cycle %0d", sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        total++;
        if (mon_e.port == 1'b0) begin
          if ({core_rsp_valid, core_rsp_data, ext_rsp_valid, ext_rsp_data} !== {1'b1, mon_e.data, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL core_rsp: got cv=%b cd=%h ev=%b ed=%h want cv=1 cd=%h ev=0 ed=0",
                     core_rsp_valid, core_rsp_data, ext_rsp_valid, ext_rsp_data, mon_e.data);
          end
        end else begin
          if ({core_rsp_valid, core_rsp_data, ext_rsp_valid, ext_rsp_data} !== {1'b0, 32'h0, 1'b1, mon_e.data}) begin
            bad++;
            $display("FAIL ext_rsp: got cv=%b cd=%h ev=%b ed=%h want cv=0 cd=0 ev=1 ed=%h",
                     core_rsp_valid, core_rsp_data, ext_rsp_valid, ext_rsp_data, mon_e.data);
          end
        end
      end else begin
        total++;
        if (core_rsp_valid !== 1'b0 || ext_rsp_valid !== 1'b0 ||
            core_rsp_data !== 32'h0 || ext_rsp_data !== 32'h0) begin
          bad++;
          $display("FAIL no_rsp: got cv=%b cd=%h ev=%b ed=%h want all zero at cycle %0d",
                   core_rsp_valid, core_rsp_data, ext_rsp_valid, ext_rsp_data, cyc);
        end
      end
    end
  end

  task automatic drive(input logic cv, input logic [1:0] cwe, input logic [31:0] ca, input logic [31:0] cd,
                       input logic ev, input logic [1:0] ewe, input logic [31:0] ea, input logic [31:0] ed);
    core_req_valid = cv; core_req_we = cwe; core_req_addr = ca; core_req_wdata = cd;
    ext_req_valid  = ev; ext_req_we  = ewe; ext_req_addr  = ea; ext_req_wdata  = ed;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 2'b00, 32'h100, 32'h0, 1'b1, 2'b00, 32'h40, 32'h0);
    #1;
    total++;
    if ({core_req_ready, ext_req_ready, mem_en, mem_we} !== 5'b0) begin
      bad++;
      $display("FAIL reset_grant: got cr=%b er=%b en=%b we=%b want all 0", core_req_ready, ext_req_ready, mem_en, mem_we);
    end
    total++;
    if ({core_rsp_valid, ext_rsp_valid, core_rsp_data, ext_rsp_data} !== 66'h0) begin
      bad++;
      $display("FAIL reset_rsp: got cv=%b ev=%b cd=%h ed=%h want 0", core_rsp_valid, ext_rsp_valid, core_rsp_data, ext_rsp_data);
    end
    total++;
    if (dut.state !== CORE_PRI || dut.u_starve.count !== 8'd0) begin
      bad++;
      $display("FAIL reset_state: got state=%b count=%0d want 0/0", dut.state, dut.u_starve.count);
    end
    idle();
  endtask

  task automatic test_core_read();
    drive(1'b1, 2'b00, 32'h100, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    total++;
    if ({core_req_ready, ext_req_ready, mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 1'b1, 2'b00, 32'h100}) begin
      bad++;
      $display("FAIL core_read_grant: got cr=%b er=%b en=%b we=%b addr=%h want 1 0 1 00 100",
               core_req_ready, ext_req_ready, mem_en, mem_we, mem_addr);
    end
    sb.push_back('{port: 1'b0, data: 32'hDEADBEEF, due: cyc + 1});
    tick();
    idle();
    #1;
    total++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== 67'h0) begin
      bad++;
      $display("FAIL idle_mem: got en=%b we=%b addr=%h wdata=%h want 0", mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
  endtask

  task automatic test_ext_write();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b11, 32'h40, 32'h12345678);
    #1;
    total++;
    if ({core_req_ready, ext_req_ready, mem_en, mem_we, mem_addr, mem_wdata} !==
        {1'b0, 1'b1, 1'b1, 2'b11, 32'h40, 32'h12345678}) begin
      bad++;
      $display("FAIL ext_write: got cr=%b er=%b en=%b we=%b addr=%h wd=%h want 0 1 1 11 40 12345678",
               core_req_ready, ext_req_ready, mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_conflict();
    drive(1'b1, 2'b11, 32'h8, 32'hAAAA5555, 1'b1, 2'b00, 32'h20, 32'h0);
    #1;
    total++;
    if ({core_req_ready, ext_req_ready, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 2'b11, 32'h8, 32'hAAAA5555}) begin
      bad++;
      $display("FAIL conflict_core: got cr=%b er=%b we=%b addr=%h wd=%h want 1 0 11 8 aaaa5555",
               core_req_ready, ext_req_ready, mem_we, mem_addr, mem_wdata);
    end
    tick();
    total++;
    if (dut.u_starve.count !== 8'd1) begin
      bad++;
      $display("FAIL conflict_count: got %0d want 1", dut.u_starve.count);
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 32'h20, 32'h0);
    #1;
    total++;
    if ({core_req_ready, ext_req_ready, mem_addr} !== {1'b0, 1'b1, 32'h20}) begin
      bad++;
      $display("FAIL conflict_ext: got cr=%b er=%b addr=%h want 0 1 20", core_req_ready, ext_req_ready, mem_addr);
    end
    sb.push_back('{port: 1'b1, data: mem_func(32'h20), due: cyc + 1});
    tick();
    idle();
    tick();
  endtask

  task automatic test_starve();
    logic [31:0] ca;
    logic        want_ext;
    for (int i = 0; i <= 6; i++) begin
      ca = 32'h1000 + 32'(4 * i);
      want_ext = (i == LIMIT + 1);
      drive(1'b1, 2'b00, ca, 32'h0, (i <= LIMIT + 1), 2'b00, 32'h200, 32'h0);
      #1;
      total++;
      if ({core_req_ready, ext_req_ready} !== {~want_ext, want_ext}) begin
        bad++;
        $display("FAIL starve_c%0d: got cr=%b er=%b want cr=%b er=%b", i, core_req_ready, ext_req_ready, ~want_ext, want_ext);
      end
      if (want_ext)
        sb.push_back('{port: 1'b1, data: mem_func(32'h200), due: cyc + 1});
      else
        sb.push_back('{port: 1'b0, data: mem_func(ca), due: cyc + 1});
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_alternating();
    logic [31:0] a;
    for (int i = 0; i < 6; i++) begin
      a = 32'(4 * i);
      if (i % 2 == 0)
        drive(1'b1, 2'b00, a, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
      else
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, a, 32'h0);
      #1;
      total++;
      if ({core_req_ready, ext_req_ready, mem_addr} !== {(i % 2 == 0), (i % 2 == 1), a}) begin
        bad++;
        $display("FAIL alt_c%0d: got cr=%b er=%b addr=%h want cr=%b addr=%h", i, core_req_ready, ext_req_ready, mem_addr, (i % 2 == 0), a);
      end
      sb.push_back('{port: (i % 2 == 1), data: mem_func(a), due: cyc + 1});
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_sat_grant();
    for (int i = 0; i < LIMIT; i++) begin
      drive(1'b1, 2'b11, 32'h80, 32'h0, 1'b1, 2'b00, 32'h300, 32'h0);
      #1;
      total++;
      if ({core_req_ready, ext_req_ready} !== 2'b10) begin
        bad++;
        $display("FAIL sat_block_c%0d: got cr=%b er=%b want 1 0", i, core_req_ready, ext_req_ready);
      end
      tick();
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 32'h300, 32'h0);
    #1;
    total++;
    if ({core_req_ready, ext_req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL sat_ext_grant: got cr=%b er=%b want 0 1", core_req_ready, ext_req_ready);
    end
    sb.push_back('{port: 1'b1, data: mem_func(32'h300), due: cyc + 1});
    tick();
    drive(1'b1, 2'b00, 32'h50, 32'h0, 1'b1, 2'b00, 32'h304, 32'h0);
    #1;
    total++;
    if ({core_req_ready, ext_req_ready} !== 2'b10) begin
      bad++;
      $display("FAIL sat_no_promote: got cr=%b er=%b want 1 0", core_req_ready, ext_req_ready);
    end
    sb.push_back('{port: 1'b0, data: mem_func(32'h50), due: cyc + 1});
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 32'h304, 32'h0);
    #1;
    sb.push_back('{port: 1'b1, data: mem_func(32'h304), due: cyc + 1});
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_mid_read();
    drive(1'b1, 2'b00, 32'h600, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    total++;
    if (core_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rmr_grant: got cr=%b want 1", core_req_ready);
    end
    tick();
    rst = 1'b1;
    drive(1'b1, 2'b00, 32'h604, 32'h0, 1'b1, 2'b00, 32'h608, 32'h0);
    #1;
    total++;
    if ({core_rsp_valid, ext_rsp_valid, core_rsp_data, core_req_ready, ext_req_ready, mem_en, mem_we} !== 39'h0) begin
      bad++;
      $display("FAIL rmr_outputs: got cv=%b ev=%b cd=%h cr=%b er=%b en=%b we=%b want all 0",
               core_rsp_valid, ext_rsp_valid, core_rsp_data, core_req_ready, ext_req_ready, mem_en, mem_we);
    end
    total++;
    if (dut.state !== CORE_PRI) begin
      bad++;
      $display("FAIL rmr_state: got %b want CORE_PRI", dut.state);
    end
    tick();
    total++;
    if (core_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmr_rsp_held: got cv=%b want 0", core_rsp_valid);
    end
    rst = 1'b0;
    drive(1'b1, 2'b00, 32'h604, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    total++;
    if (core_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rmr_first_grant: got cr=%b want 1", core_req_ready);
    end
    sb.push_back('{port: 1'b0, data: mem_func(32'h604), due: cyc + 1});
    tick();
    idle();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    tick();
    test_core_read();
    test_ext_write();
    test_conflict();
    test_starve();
    test_alternating();
    test_sat_grant();
    test_reset_mid_read();
    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d entries left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
